// File: rtl/mmio_input_device_pkg.sv
// rtl/mmio_input_device_pkg.sv - register addresses, control-word layout and flag update rule for the board-input responder
package mmio_input_device_pkg;

  localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] SDATA_ADDR = 32'hF000_0014;
  localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;
  localparam logic [31:0] SCTRL_ADDR = 32'hF000_0114;

  localparam int CTRL_RDY_BIT = 0;
  localparam int CTRL_OVR_BIT = 2;
  localparam int CTRL_IE_BIT  = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KDATA,
    SEL_SDATA,
    SEL_KCTRL,
    SEL_SCTRL
  } regSel_t;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic rdy;
  } chanFlags_t;

  function automatic logic [31:0] packCtrl(input chanFlags_t f);
    logic [31:0] w;
    w = '0;
    w[CTRL_IE_BIT]  = f.ie;
    w[CTRL_OVR_BIT] = f.ovr;
    w[CTRL_RDY_BIT] = f.rdy;
    return w;
  endfunction

  // An overrun raised by an event outranks a same-edge software clear; a data read racing an event keeps READY.
  function automatic chanFlags_t nextFlags(input chanFlags_t cur, input logic ev, input logic rd,
                                           input logic wr, input logic wrIe, input logic wrKeepOvr);
    chanFlags_t nxt;
    nxt = cur;
    if (wr) begin
      nxt.ie = wrIe;
      if (!wrKeepOvr) nxt.ovr = 1'b0;
    end
    if (ev && cur.rdy && !rd) nxt.ovr = 1'b1;
    if (ev) nxt.rdy = 1'b1;
    else if (rd) nxt.rdy = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// rtl/mmio_debounce.sv - commits a synchronized vector once a new value has held for CYCLES consecutive edges
module mmio_debounce #(
  parameter int WIDTH  = 10,
  parameter int CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] syncIn,
  output logic [WIDTH-1:0] committed,
  output logic             commit
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] prevSync;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countNext;

  // The edge on which a new value first appears counts as stable edge number one.
  always_comb begin
    countNext = (syncIn != prevSync) ? CW'(1) : count + CW'(1);
    commit    = (syncIn != committed) && (countNext == CW'(CYCLES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevSync  <= '0;
      count     <= '0;
      committed <= '0;
    end else begin
      prevSync <= syncIn;
      if ((syncIn == committed) || commit) count <= '0;
      else count <= countNext;
      if (commit) committed <= syncIn;
    end
  end

endmodule

// File: rtl/mmio_input_device.sv
// rtl/mmio_input_device.sv - memory-mapped KEY/SW responder with sticky ready/overrun flags and interrupt request
module mmio_input_device
  import mmio_input_device_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(SDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KCTRL_ADDR),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(SCTRL_ADDR),
  parameter int               DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic             rdEn,
  input  logic [DBITS-1:0] dIn,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [DBITS-1:0] dOut,
  output logic             hit,
  output logic             intr
);

  logic [3:0] keyMeta;
  logic [3:0] kData;
  logic [9:0] swMeta;
  logic [9:0] swSync;
  logic [9:0] sData;
  logic       kEvent;
  logic       sEvent;
  logic       kRead, sRead, kCtrlWr, sCtrlWr;
  chanFlags_t kFlags, sFlags;
  regSel_t    sel;
  logic       unusedDIn;

  always_comb begin
    sel = SEL_NONE;
    if (addr == ADDR_KDATA) sel = SEL_KDATA;
    else if (addr == ADDR_SDATA) sel = SEL_SDATA;
    else if (addr == ADDR_KCTRL) sel = SEL_KCTRL;
    else if (addr == ADDR_SCTRL) sel = SEL_SCTRL;
  end

  assign hit     = (sel != SEL_NONE);
  assign kRead   = rdEn  && (sel == SEL_KDATA);
  assign sRead   = rdEn  && (sel == SEL_SDATA);
  assign kCtrlWr = wrtEn && (sel == SEL_KCTRL);
  assign sCtrlWr = wrtEn && (sel == SEL_SCTRL);

  // kData doubles as the second synchronizer stage, so a key change is visible two edges after the pin moves.
  assign kEvent = (~keyMeta != kData);

  mmio_debounce #(
    .WIDTH (10),
    .CYCLES(DEBOUNCE_CYCLES)
  ) swDebounce (
    .clk      (clk),
    .reset    (reset),
    .syncIn   (swSync),
    .committed(sData),
    .commit   (sEvent)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyMeta <= 4'hF;
      kData   <= '0;
      swMeta  <= '0;
      swSync  <= '0;
      kFlags  <= '0;
      sFlags  <= '0;
    end else begin
      keyMeta <= key;
      if (kEvent) kData <= ~keyMeta;
      swMeta  <= sw;
      swSync  <= swMeta;
      kFlags  <= nextFlags(kFlags, kEvent, kRead, kCtrlWr, dIn[CTRL_IE_BIT], dIn[CTRL_OVR_BIT]);
      sFlags  <= nextFlags(sFlags, sEvent, sRead, sCtrlWr, dIn[CTRL_IE_BIT], dIn[CTRL_OVR_BIT]);
    end
  end

  always_comb begin
    dOut = '0;
    case (sel)
      SEL_KDATA: dOut = DBITS'(kData);
      SEL_SDATA: dOut = DBITS'(sData);
      SEL_KCTRL: dOut = DBITS'(packCtrl(kFlags));
      SEL_SCTRL: dOut = DBITS'(packCtrl(sFlags));
      default:   dOut = '0;
    endcase
  end

  assign intr = (kFlags.rdy & kFlags.ie) | (sFlags.rdy & sFlags.ie);

  assign unusedDIn = ^dIn;

endmodule

// File: tb/tb_mmio_input_device.sv
// tb/tb_mmio_input_device.sv - randomized and directed bench for mmio_input_device against a behavioural model
module tb_mmio_input_device;

  localparam int CYC = 4;
  localparam logic [31:0] A_KD = 32'hF000_0010;
  localparam logic [31:0] A_SD = 32'hF000_0014;
  localparam logic [31:0] A_KC = 32'hF000_0110;
  localparam logic [31:0] A_SC = 32'hF000_0114;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] dIn   = '0;
  logic        wrtEn = 1'b0;
  logic        rdEn  = 1'b0;
  logic [3:0]  key   = 4'hF;
  logic [9:0]  sw    = '0;
  logic [31:0] dOut;
  logic        hit;
  logic        intr;

  int compared   = 0;
  int mismatched = 0;

  mmio_input_device #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wrtEn(wrtEn),
    .rdEn (rdEn),
    .dIn  (dIn),
    .key  (key),
    .sw   (sw),
    .dOut (dOut),
    .hit  (hit),
    .intr (intr)
  );

  always #5 clk = ~clk;

  // Model: channel 0 is KEY, channel 1 is SW.
  logic [3:0] mK;
  logic [9:0] mS;
  bit         mRdy[2];
  bit         mOvr[2];
  bit         mIe[2];
  logic [3:0] kPipe[$];
  logic [9:0] swPipe[$];
  logic [9:0] swWin[$];

  task automatic modelReset();
    mK = '0;
    mS = '0;
    for (int c = 0; c < 2; c++) begin
      mRdy[c] = 0;
      mOvr[c] = 0;
      mIe[c]  = 0;
    end
    kPipe  = '{4'h0};
    swPipe = '{10'h0, 10'h0};
    swWin.delete();
  endtask

  task automatic modelStep();
    logic [3:0] kNow;
    logic [9:0] sNow;
    bit ev[2];
    bit rd[2];
    bit wr[2];
    bit commit;
    bit over;
    kPipe.push_back(~key);
    kNow = kPipe.pop_front();
    swPipe.push_back(sw);
    sNow = swPipe.pop_front();
    swWin.push_back(sNow);
    if (swWin.size() > CYC) void'(swWin.pop_front());
    commit = (swWin.size() == CYC) && (sNow != mS);
    foreach (swWin[i]) if (swWin[i] != sNow) commit = 0;
    ev[0] = (kNow != mK);
    ev[1] = commit;
    rd[0] = rdEn && (addr == A_KD);
    rd[1] = rdEn && (addr == A_SD);
    wr[0] = wrtEn && (addr == A_KC);
    wr[1] = wrtEn && (addr == A_SC);
    for (int c = 0; c < 2; c++) begin
      over = ev[c] && mRdy[c] && !rd[c];
      if (wr[c]) begin
        mIe[c] = dIn[8];
        if (!dIn[2]) mOvr[c] = 0;
      end
      if (over) mOvr[c] = 1;
      if (ev[c]) mRdy[c] = 1;
      else if (rd[c]) mRdy[c] = 0;
    end
    if (ev[0]) mK = kNow;
    if (commit) mS = sNow;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else modelStep();
  end

  function automatic logic [31:0] ctrlWord(input int c);
    return {23'b0, mIe[c], 5'b0, mOvr[c], 1'b0, mRdy[c]};
  endfunction

  function automatic logic [31:0] expD(input logic [31:0] a);
    case (a)
      A_KD:    return {28'b0, mK};
      A_SD:    return {22'b0, mS};
      A_KC:    return ctrlWord(0);
      A_SC:    return ctrlWord(1);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_dout", dOut, expD(addr));
    check("model_hit", {31'b0, hit}, {31'b0, (addr == A_KD) || (addr == A_SD) || (addr == A_KC) || (addr == A_SC)});
    check("model_intr", {31'b0, intr}, {31'b0, (mRdy[0] && mIe[0]) || (mRdy[1] && mIe[1])});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr  = a;
    rdEn  = 0;
    wrtEn = 0;
    #1;
    check(nm, dOut, exp);
  endtask

  logic [31:0] regAddr[4];
  int r;

  initial begin
    regAddr = '{A_KD, A_SD, A_KC, A_SC};
    repeat (2) @(posedge clk);
    #2 reset = 0;
    step(1);

    peek(A_KD, 32'h0, "rst_kdata");
    peek(A_KC, 32'h0, "rst_kctrl");
    peek(A_SC, 32'h0, "rst_sctrl");
    check("rst_intr", {31'b0, intr}, 32'h0);
    addr = 32'h0000_0100;
    #1;
    check("rst_hit", {31'b0, hit}, 32'h0);
    check("rst_dout_miss", dOut, 32'h0);

    key = 4'b1101;
    step(2);
    peek(A_KD, 32'h2, "key_kdata");
    peek(A_KC, 32'h1, "key_kctrl");
    addr = A_KD;
    rdEn = 1;
    step(1);
    rdEn = 0;
    peek(A_KC, 32'h0, "read_clears_rdy");

    key = 4'hF;
    step(2);
    key = 4'b1101;
    step(2);
    peek(A_KC, 32'h5, "overrun");
    addr  = A_KC;
    wrtEn = 1;
    dIn   = 32'h100;
    step(1);
    wrtEn = 0;
    peek(A_KC, 32'h101, "ie_set_ovr_clr");
    check("intr_on", {31'b0, intr}, 32'h1);
    addr  = A_KC;
    wrtEn = 1;
    dIn   = 32'h0;
    step(1);
    wrtEn = 0;
    peek(A_KC, 32'h1, "ie_clr");
    check("intr_off", {31'b0, intr}, 32'h0);

    sw = 10'h3FF;
    step(3);
    sw = 10'h0;
    step(6);
    peek(A_SD, 32'h0, "glitch_sdata");
    peek(A_SC, 32'h0, "glitch_sctrl");
    sw = 10'h2A5;
    step(5);
    peek(A_SD, 32'h0, "db_early");
    step(1);
    peek(A_SD, 32'h2A5, "db_commit");
    peek(A_SC, 32'h1, "db_sctrl");

    key = 4'hF;
    step(1);
    addr = A_KD;
    rdEn = 1;
    step(1);
    rdEn = 0;
    peek(A_KC, 32'h1, "read_event_same_edge");
    peek(A_KD, 32'h0, "read_event_kdata");

    key = 4'b1101;
    step(1);
    addr  = A_KC;
    wrtEn = 1;
    dIn   = 32'h0;
    step(1);
    wrtEn = 0;
    peek(A_KC, 32'h5, "ovr_beats_clear");

    sw = 10'h155;
    step(3);
    #1 reset = 1;
    #1;
    peek(A_KC, 32'h0, "arst_kctrl");
    peek(A_SD, 32'h0, "arst_sdata");
    peek(A_KD, 32'h0, "arst_kdata");
    check("arst_intr", {31'b0, intr}, 32'h0);
    step(1);
    reset = 0;
    step(5);
    peek(A_SD, 32'h0, "post_rst_early");
    peek(A_KD, 32'h2, "post_rst_key");
    step(1);
    peek(A_SD, 32'h155, "post_rst_commit");

    for (int i = 0; i < 3000; i++) begin
      step(1);
      r = $urandom_range(0, 5);
      addr  = (r < 4) ? regAddr[r] : $urandom;
      rdEn  = ($urandom_range(0, 3) == 0);
      wrtEn = ($urandom_range(0, 3) == 0);
      dIn   = $urandom;
      if ($urandom_range(0, 7) == 0) key = 4'($urandom);
      r = $urandom_range(0, 19);
      if (r == 0) sw = 10'($urandom);
      else if (r == 1) sw = sw ^ (10'h1 << $urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1;
        #1 reset = 0;
      end
    end

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
